// File: rtl/umem_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one single-ported unified memory.
// Data has priority, capped by a streak limit; out-of-range data accesses are answered locally with d_err.
module umem_arbiter #(
   parameter int          ADDR_W       = 12,
   parameter logic [31:0] IF_BASE      = 32'h0000_3000,
   parameter int          MAX_D_STREAK = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic [3:0]        d_byteen,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              mem_en,
   output logic [3:0]        mem_byteen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int DSTK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
   localparam logic [DSTK_W-1:0] DSTK_MAX = DSTK_W'(MAX_D_STREAK);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_D,
      OWN_DERR
   } own_t;

   own_t              own;
   own_t              own_next;
   logic [DSTK_W-1:0] dstk;
   logic [DSTK_W-1:0] dstk_next;
   logic              d_read;
   logic              d_read_next;
   logic              if_elig;
   logic              d_elig;
   logic              grant_if;
   logic              grant_d;
   logic              d_in_range;
   logic [31:0]       if_offset;
   logic              unused_bits;

   assign unused_bits = ^{d_addr[1:0], if_offset[31:ADDR_W+2], if_offset[1:0]};

   always_ff @(posedge clk) begin
      if (!reset) begin
         own    <= OWN_NONE;
         dstk   <= '0;
         d_read <= 1'b0;
      end else begin
         own    <= own_next;
         dstk   <= dstk_next;
         d_read <= d_read_next;
      end
   end

   // A requester in its ack cycle is not eligible, so the other side gets the slot with no bubble.
   always_comb begin
      if_offset   = if_addr - IF_BASE;
      d_in_range  = (d_addr[31:ADDR_W+2] == '0);
      if_elig     = if_req && (own != OWN_IF);
      d_elig      = d_req && (own != OWN_D) && (own != OWN_DERR);
      grant_d     = d_elig && !(if_elig && (dstk == DSTK_MAX));
      grant_if    = if_elig && !grant_d;

      mem_en      = 1'b0;
      mem_byteen  = 4'b0000;
      mem_addr    = '0;
      mem_wdata   = 32'd0;
      own_next    = OWN_NONE;
      dstk_next   = '0;
      d_read_next = d_read;

      if (grant_if) begin
         mem_en   = 1'b1;
         mem_addr = if_offset[ADDR_W+1:2];
         own_next = OWN_IF;
      end else if (grant_d) begin
         d_read_next = (d_byteen == 4'b0000);
         if (d_in_range) begin
            mem_en     = 1'b1;
            mem_byteen = d_byteen;
            mem_addr   = d_addr[ADDR_W+1:2];
            mem_wdata  = d_wdata;
            own_next   = OWN_D;
         end else begin
            own_next = OWN_DERR;
         end
         if (if_elig) begin
            dstk_next = (dstk == DSTK_MAX) ? dstk : dstk + DSTK_W'(1);
         end
      end

      if (!reset) begin
         mem_en     = 1'b0;
         mem_byteen = 4'b0000;
         mem_addr   = '0;
         mem_wdata  = 32'd0;
      end
   end

   // Acks follow the owner register; write acks and error acks return zero data.
   always_comb begin
      if_ack   = 1'b0;
      if_rdata = 32'd0;
      d_ack    = 1'b0;
      d_rdata  = 32'd0;
      d_err    = 1'b0;
      if (reset) begin
         case (own)
            OWN_IF: begin
               if_ack   = 1'b1;
               if_rdata = mem_rdata;
            end
            OWN_D: begin
               d_ack   = 1'b1;
               d_rdata = d_read ? mem_rdata : 32'd0;
            end
            OWN_DERR: begin
               d_ack = 1'b1;
               d_err = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_umem_arbiter.sv
// Directed scoreboard bench for umem_arbiter with a behavioural one-cycle-latency memory.
// Stimulus pushes expected acks into per-requester queues; a negedge monitor pops and compares.
module tb_umem_arbiter;

   localparam int ADDR_W = 12;

   logic              clk;
   logic              reset;
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_ack;
   logic [31:0]       if_rdata;
   logic              d_req;
   logic [3:0]        d_byteen;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_ack;
   logic [31:0]       d_rdata;
   logic              d_err;
   logic              mem_en;
   logic [3:0]        mem_byteen;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [31:0] mem_model [0:(1<<ADDR_W)-1];
   logic [31:0] exp_if [$];
   logic [32:0] exp_d [$];
   int compared;
   int mismatched;

   umem_arbiter #(
      .ADDR_W(ADDR_W),
      .IF_BASE(32'h0000_3000),
      .MAX_D_STREAK(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_ack(if_ack),
      .if_rdata(if_rdata),
      .d_req(d_req),
      .d_byteen(d_byteen),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_ack(d_ack),
      .d_rdata(d_rdata),
      .d_err(d_err),
      .mem_en(mem_en),
      .mem_byteen(mem_byteen),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural synchronous memory: read data appears the cycle after mem_en.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_byteen == 4'b0000) begin
            mem_rdata <= mem_model[mem_addr];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteen[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor pops one expectation per ack and compares the returned data.
   always @(negedge clk) begin
      if (if_ack) begin
         if (exp_if.size() == 0) begin
            checkOutput("if_ack_unexpected", 32'(if_ack), 32'd0);
         end else begin
            checkOutput("if_rdata", if_rdata, exp_if.pop_front());
         end
      end
      if (d_ack) begin
         if (exp_d.size() == 0) begin
            checkOutput("d_ack_unexpected", 32'(d_ack), 32'd0);
         end else begin
            logic [32:0] e;
            e = exp_d.pop_front();
            checkOutput("d_rdata", d_rdata, e[31:0]);
            checkOutput("d_err", 32'(d_err), 32'(e[32]));
         end
      end
   end

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic if_access(input logic [31:0] addr, input logic [31:0] exp_data);
      int n;
      exp_if.push_back(exp_data);
      if_req  = 1'b1;
      if_addr = addr;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!if_ack && n < 20);
      if (!if_ack) checkOutput("if_ack_timeout", 32'(if_ack), 32'd1);
      if_req = 1'b0;
   endtask

   task automatic d_access(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic exp_err);
      int n;
      exp_d.push_back({exp_err, exp_data});
      d_req    = 1'b1;
      d_addr   = addr;
      d_byteen = be;
      d_wdata  = wdata;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!d_ack && n < 20);
      if (!d_ack) checkOutput("d_ack_timeout", 32'(d_ack), 32'd1);
      d_req = 1'b0;
   endtask

   task automatic applyStimulus();
      // Reset gating: requests present while reset is low must produce nothing.
      repeat (2) @(posedge clk);
      #1;
      if_req  = 1'b1;
      if_addr = 32'h0000_3004;
      d_req   = 1'b1;
      d_addr  = 32'h0000_0010;
      #1;
      checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
      checkOutput("reset_if_ack", 32'(if_ack), 32'd0);
      checkOutput("reset_d_ack", 32'(d_ack), 32'd0);
      @(posedge clk);
      #1;
      if_req = 1'b0;
      d_req  = 1'b0;
      reset  = 1'b1;
      idle();

      // Single fetch, held through its ack: re-granted at N+2.
      if_req  = 1'b1;
      if_addr = 32'h0000_3004;
      exp_if.push_back(32'hDEAD_BEEF);
      #1;
      checkOutput("if_grant_en", 32'(mem_en), 32'd1);
      checkOutput("if_grant_addr", 32'(mem_addr), 32'd1);
      checkOutput("if_grant_byteen", 32'(mem_byteen), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("if_ack_cycle_no_grant", 32'(mem_en), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("if_regrant_en", 32'(mem_en), 32'd1);
      checkOutput("if_regrant_addr", 32'(mem_addr), 32'd1);
      exp_if.push_back(32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      checkOutput("if_second_ack", 32'(if_ack), 32'd1);
      if_req = 1'b0;
      idle();

      // Partial write, then read it back.
      d_req    = 1'b1;
      d_byteen = 4'b0011;
      d_addr   = 32'h0000_0010;
      d_wdata  = 32'h1234_5678;
      exp_d.push_back({1'b0, 32'd0});
      #1;
      checkOutput("d_wr_en", 32'(mem_en), 32'd1);
      checkOutput("d_wr_byteen", 32'(mem_byteen), 32'h3);
      checkOutput("d_wr_addr", 32'(mem_addr), 32'd4);
      checkOutput("d_wr_wdata", mem_wdata, 32'h1234_5678);
      @(posedge clk);
      #1;
      checkOutput("d_wr_ack", 32'(d_ack), 32'd1);
      d_req = 1'b0;
      idle();
      d_access(32'h0000_0010, 4'b0000, 32'd0, 32'hA500_5678, 1'b0);
      idle();
      d_access(32'h0000_001B, 4'b1100, 32'hAABB_CCDD, 32'd0, 1'b0);
      idle();
      d_access(32'h0000_0018, 4'b0000, 32'd0, 32'hAABB_0006, 1'b0);
      idle();

      // Out-of-range data read is answered locally.
      d_req    = 1'b1;
      d_byteen = 4'b0000;
      d_addr   = 32'h0000_7F20;
      exp_d.push_back({1'b1, 32'd0});
      #1;
      checkOutput("d_err_no_mem_en", 32'(mem_en), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("d_err_ack", 32'(d_ack), 32'd1);
      d_req = 1'b0;
      idle();

      // Fetch index wraps modulo memory depth, including below the base.
      if_access(32'h0000_7008, 32'hA500_0002);
      idle();
      if_access(32'h0000_2FFC, 32'hA500_0FFF);
      idle();

      // Both requesting every cycle: D, IF, D, IF ...
      if_req   = 1'b1;
      if_addr  = 32'h0000_3014;
      d_req    = 1'b1;
      d_byteen = 4'b0000;
      d_addr   = 32'h0000_0020;
      #1;
      for (int k = 0; k < 6; k++) begin
         checkOutput("alt_mem_en", 32'(mem_en), 32'd1);
         if (k % 2 == 0) begin
            checkOutput("alt_d_addr", 32'(mem_addr), 32'd8);
            exp_d.push_back({1'b0, 32'hA500_0008});
         end else begin
            checkOutput("alt_if_addr", 32'(mem_addr), 32'd5);
            exp_if.push_back(32'hA500_0005);
         end
         @(posedge clk);
         #1;
      end
      if_req = 1'b0;
      #1;
      checkOutput("alt_last_d_addr", 32'(mem_addr), 32'd8);
      exp_d.push_back({1'b0, 32'hA500_0008});
      @(posedge clk);
      #1;
      d_req = 1'b0;
      #1;
      checkOutput("alt_drain_en", 32'(mem_en), 32'd0);
      idle();

      // D raised during the IF ack cycle is granted immediately.
      if_req  = 1'b1;
      if_addr = 32'h0000_3008;
      exp_if.push_back(32'hA500_0002);
      #1;
      checkOutput("handoff_if_addr", 32'(mem_addr), 32'd2);
      @(posedge clk);
      #1;
      checkOutput("handoff_if_ack", 32'(if_ack), 32'd1);
      if_req   = 1'b0;
      d_req    = 1'b1;
      d_byteen = 4'b0000;
      d_addr   = 32'h0000_0014;
      exp_d.push_back({1'b0, 32'hA500_0005});
      #1;
      checkOutput("handoff_d_en", 32'(mem_en), 32'd1);
      checkOutput("handoff_d_addr", 32'(mem_addr), 32'd5);
      @(posedge clk);
      #1;
      checkOutput("handoff_d_ack", 32'(d_ack), 32'd1);
      d_req = 1'b0;
      idle();

      // Reset during a grant cycle abandons the access.
      if_req  = 1'b1;
      if_addr = 32'h0000_3004;
      #1;
      checkOutput("rst_grant_en", 32'(mem_en), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("rst_gated_en", 32'(mem_en), 32'd0);
      @(posedge clk);
      #1;
      reset  = 1'b1;
      if_req = 1'b0;
      checkOutput("rst_no_ack", 32'(if_ack), 32'd0);
      idle();
      if_access(32'h0000_3004, 32'hDEAD_BEEF);
      repeat (3) idle();

      checkOutput("if_queue_empty", 32'(exp_if.size()), 32'd0);
      checkOutput("d_queue_empty", 32'(exp_d.size()), 32'd0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      if_req     = 1'b0;
      if_addr    = 32'd0;
      d_req      = 1'b0;
      d_byteen   = 4'b0000;
      d_addr     = 32'd0;
      d_wdata    = 32'd0;
      mem_rdata  = 32'd0;
      for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = 32'hA500_0000 | i;
      mem_model[1] = 32'hDEAD_BEEF;
      applyStimulus();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
